// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmitter.
package uart_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StParity,
      StStop
   } uart_state_e;

   localparam logic UART_IDLE_LEVEL  = 1'b1;
   localparam logic UART_START_LEVEL = 1'b0;

   // Bit periods per frame: start + data + optional parity + stop.
   function automatic int unsigned uart_frame_len(input int unsigned data_bits,
                                                  input int unsigned stop_bits,
                                                  input bit          parity);
      return 1 + data_bits + (parity ? 1 : 0) + stop_bits;
   endfunction

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: one-entry holding register feeding a baud-tick driven shift engine.
// Define UART_TX_PARITY_EN to insert a parity bit (sense set by PARITY_ODD) after the data bits.
module uart_tx
   import uart_pkg::*;
#(
   parameter int unsigned DATA_BITS  = 8,
   parameter int unsigned STOP_BITS  = 1,
   parameter int unsigned PARITY_ODD = 0
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 baud_tick,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   output logic                 tx,
   output logic                 tx_busy
);

   if (DATA_BITS < 5 || DATA_BITS > 8 || STOP_BITS < 1 || STOP_BITS > 2 || PARITY_ODD > 1)
   begin : gen_param_check
      $error("uart_tx: illegal parameter combination");
   end

   localparam logic [2:0] LastData = 3'(DATA_BITS - 1);
   localparam logic [2:0] LastStop = 3'(STOP_BITS - 1);

   uart_state_e          state_q, state_d;
   logic [DATA_BITS-1:0] hold_q, hold_d;
   logic                 hold_valid_q, hold_valid_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [2:0]           cnt_q, cnt_d;
   logic                 tx_q, tx_d;
   logic                 accept;
   logic                 load;
`ifdef UART_TX_PARITY_EN
   logic                 par_q, par_d;
`endif

   assign accept   = tx_valid && !hold_valid_q;
   assign tx_ready = !hold_valid_q;
   assign tx       = tx_q;
   assign tx_busy  = (state_q != StIdle) || hold_valid_q;

   always_comb begin
      state_d      = state_q;
      hold_d       = hold_q;
      hold_valid_d = hold_valid_q;
      shift_d      = shift_q;
      cnt_d        = cnt_q;
      tx_d         = tx_q;
      load         = 1'b0;
`ifdef UART_TX_PARITY_EN
      par_d        = par_q;
`endif

      unique case (state_q)
         StIdle: begin
            if (baud_tick && hold_valid_q) begin
               load = 1'b1;
            end
         end
         StStart: begin
            if (baud_tick) begin
               state_d = StData;
               tx_d    = shift_q[0];
            end
         end
         StData: begin
            if (baud_tick) begin
               if (cnt_q == LastData) begin
                  cnt_d   = '0;
`ifdef UART_TX_PARITY_EN
                  state_d = StParity;
                  tx_d    = par_q;
`else
                  state_d = StStop;
                  tx_d    = UART_IDLE_LEVEL;
`endif
               end else begin
                  cnt_d   = cnt_q + 3'd1;
                  shift_d = shift_q >> 1;
                  tx_d    = shift_q[1];
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         StParity: begin
            if (baud_tick) begin
               state_d = StStop;
               tx_d    = UART_IDLE_LEVEL;
            end
         end
`endif
         StStop: begin
            if (baud_tick) begin
               if (cnt_q == LastStop) begin
                  cnt_d = '0;
                  // A waiting byte starts its frame immediately, with no idle bit.
                  if (hold_valid_q) begin
                     load = 1'b1;
                  end else begin
                     state_d = StIdle;
                     tx_d    = UART_IDLE_LEVEL;
                  end
               end else begin
                  cnt_d = cnt_q + 3'd1;
               end
            end
         end
         default: state_d = StIdle;
      endcase

      if (load) begin
         shift_d = hold_q;
         state_d = StStart;
         tx_d    = UART_START_LEVEL;
         cnt_d   = '0;
`ifdef UART_TX_PARITY_EN
         par_d   = (^hold_q) ^ PARITY_ODD[0];
`endif
      end

      hold_valid_d = (hold_valid_q && !load) || accept;
      if (accept) begin
         hold_d = tx_data;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= StIdle;
         hold_q       <= '0;
         hold_valid_q <= 1'b0;
         shift_q      <= '0;
         cnt_q        <= '0;
         tx_q         <= UART_IDLE_LEVEL;
`ifdef UART_TX_PARITY_EN
         par_q        <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         hold_q       <= hold_d;
         hold_valid_q <= hold_valid_d;
         shift_q      <= shift_d;
         cnt_q        <= cnt_d;
         tx_q         <= tx_d;
`ifdef UART_TX_PARITY_EN
         par_q        <= par_d;
`endif
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: random bytes decoded by a behavioural line receiver.
// Honours UART_TX_PARITY_EN to expect the parity bit.
module tb_uart_tx;

   localparam int unsigned DataBits  = 8;
   localparam int unsigned StopBits  = 1;
   localparam int unsigned ParityOdd = 0;
`ifdef UART_TX_PARITY_EN
   localparam int unsigned ParBits   = 1;
`else
   localparam int unsigned ParBits   = 0;
`endif
   localparam int unsigned FrameLen  = 1 + DataBits + ParBits + StopBits;

   logic                clock;
   logic                reset;
   logic                baud_tick;
   logic [DataBits-1:0] tx_data;
   logic                tx_valid;
   logic                tx_ready;
   logic                tx;
   logic                tx_busy;

   uart_tx #(
      .DATA_BITS (DataBits),
      .STOP_BITS (StopBits),
      .PARITY_ODD(ParityOdd)
   ) dut (
      .clock    (clock),
      .reset    (reset),
      .baud_tick(baud_tick),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .tx       (tx),
      .tx_busy  (tx_busy)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // One tick every 16 clocks.
   initial begin
      baud_tick = 1'b0;
      forever begin
         repeat (15) @(posedge clock);
         #1 baud_tick = 1'b1;
         @(posedge clock);
         #1 baud_tick = 1'b0;
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   // Reference: bytes accepted by the source, in order.
   logic [7:0] sb[$];

   // Line receiver: one slot per tick interval, sampled just after the tick edge.
   int         slot       = 0;
   int         rx_phase   = 0;
   int         rx_i       = 0;
   int         start_slot = -1;
   int         last_gap   = 0;
   logic [7:0] rx_byte;
   logic [7:0] exp_b;
   logic       prev_tx;
   logic       e_tick;
   logic       e_rst;

   initial begin
      prev_tx = 1'b1;
      forever begin
         @(posedge clock);
         e_tick = baud_tick;
         e_rst  = reset;
         @(negedge clock);
         if (e_rst) begin
            rx_phase   = 0;
            start_slot = -1;
         end else begin
            if (tx !== prev_tx) check("tx_moves_on_tick_only", 32'(e_tick), 1);
            if (e_tick) begin
               slot++;
               case (rx_phase)
                  0: if (tx === 1'b0) begin
                     rx_phase = 1;
                     rx_i     = 0;
                     rx_byte  = '0;
                     if (start_slot >= 0) last_gap = slot - start_slot;
                     start_slot = slot;
                  end
                  1: begin
                     rx_byte[rx_i] = tx;
                     rx_i++;
                     if (rx_i == DataBits) begin
                        rx_i     = 0;
                        rx_phase = (ParBits != 0) ? 2 : 3;
                     end
                  end
                  2: begin
                     check("rx_parity", 32'(tx), 32'((^rx_byte) ^ (ParityOdd != 0)));
                     rx_phase = 3;
                  end
                  3: begin
                     check("rx_stop_bit", 32'(tx), 1);
                     rx_i++;
                     if (rx_i == StopBits) begin
                        rx_phase = 0;
                        check("rx_frame_expected", 32'(sb.size() > 0), 1);
                        if (sb.size() > 0) begin
                           exp_b = sb.pop_front();
                           check("rx_byte", 32'(rx_byte), 32'(exp_b));
                        end
                     end
                  end
                  default: rx_phase = 0;
               endcase
            end
         end
         prev_tx = tx;
      end
   end

   task automatic send(input logic [7:0] b);
      int n;
      n        = 0;
      tx_data  = b;
      tx_valid = 1'b1;
      while (!tx_ready && n < 5000) begin
         @(posedge clock); #1;
         n++;
      end
      if (!tx_ready) begin
         check("send_ready_timeout", 32'(tx_ready), 1);
         tx_valid = 1'b0;
         return;
      end
      @(posedge clock); #1;
      sb.push_back(b);
      tx_valid = 1'b0;
      tx_data  = 8'($urandom);
   endtask

   task automatic wait_idle(input string tag);
      int n;
      n = 0;
      while (tx_busy && n < 20000) begin
         @(posedge clock); #1;
         n++;
      end
      check({tag, "_idle_timeout"}, 32'(tx_busy), 0);
      repeat (2) @(posedge clock);
      #1;
   endtask

   task automatic wait_ticks(input int k);
      int seen;
      int n;
      seen = 0;
      n    = 0;
      while (seen < k && n < 20 * k + 20) begin
         @(posedge clock);
         if (baud_tick) seen++;
         #1;
         n++;
      end
      check("wait_ticks_timeout", seen, k);
   endtask

   int   bad;
   int   n;
   int   ticks;
   logic t;

   initial begin
      reset    = 1'b1;
      tx_valid = 1'b0;
      tx_data  = '0;
      @(posedge clock); #1;
      check("reset_tx", 32'(tx), 1);
      check("reset_tx_ready", 32'(tx_ready), 1);
      check("reset_tx_busy", 32'(tx_busy), 0);
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;

      bad = 0;
      repeat (500) begin
         @(posedge clock); #1;
         if (tx !== 1'b1 || tx_ready !== 1'b1 || tx_busy !== 1'b0) bad++;
      end
      check("idle_500_clocks", bad, 0);

      // Single frame: latency, idle before start, frame length in ticks.
      send(8'h55);
      check("ready_low_after_accept", 32'(tx_ready), 0);
      check("busy_after_accept", 32'(tx_busy), 1);
      bad = 0;
      n   = 0;
      t   = 1'b0;
      while (!t && n < 64) begin
         @(posedge clock);
         t = baud_tick;
         #1;
         n++;
         if (!t && tx !== 1'b1) bad++;
      end
      check("pre_start_idle", bad, 0);
      check("start_latency", 32'(tx), 0);
      ticks = 0;
      n     = 0;
      while (tx_busy && n < 2000) begin
         @(posedge clock);
         if (baud_tick) ticks++;
         #1;
         n++;
      end
      check("busy_len_ticks", ticks, FrameLen);
      check("tx_idle_after_frame", 32'(tx), 1);
      check("ready_after_frame", 32'(tx_ready), 1);
      repeat (2) @(posedge clock);
      #1;

      // Back-to-back frames leave no idle bit.
      send(8'hA5);
      check("ready_low_hold_full", 32'(tx_ready), 0);
      send(8'h3C);
      check("ready_low_second", 32'(tx_ready), 0);
      wait_idle("b2b");
      check("b2b_gap", last_gap, FrameLen);
      check("b2b_sb_drained", sb.size(), 0);

      // Byte offered while hold is full must be ignored.
      send(8'h21);
      send(8'h43);
      tx_data  = 8'h12;
      tx_valid = 1'b1;
      bad      = 0;
      repeat (20) begin
         @(posedge clock); #1;
         if (tx_ready !== 1'b0) bad++;
      end
      tx_valid = 1'b0;
      check("ready_low_while_full", bad, 0);
      wait_idle("ignore");
      check("ignore_sb_drained", sb.size(), 0);

      // Reset inside the 4th data bit, with a second byte held.
      send(8'hFF);
      send(8'h99);
      wait_ticks(4);
      repeat (5) @(posedge clock);
      #1 reset = 1'b1;
      @(posedge clock); #1;
      check("midreset_tx", 32'(tx), 1);
      check("midreset_busy", 32'(tx_busy), 0);
      check("midreset_ready", 32'(tx_ready), 1);
      sb.delete();
      reset = 1'b0;
      repeat (40) @(posedge clock);
      #1;
      check("post_reset_idle_busy", 32'(tx_busy), 0);
      send(8'h0F);
      wait_idle("after_reset");
      check("after_reset_sb_drained", sb.size(), 0);

      // Parity pattern plus random traffic with random gaps.
      send(8'h07);
      for (int i = 0; i < 24; i++) begin
         send(8'($urandom));
         repeat ($urandom_range(0, 200)) @(posedge clock);
         #1;
      end
      wait_idle("random");
      check("random_sb_drained", sb.size(), 0);
      check("final_tx_idle", 32'(tx), 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
